// File: rtl/tau_cfg_pkg.sv
// Read-pipeline configuration constants used by the allocator-side blocks.
package TauCfg;
  localparam int LOCAL_ADDR_BW0 = 16;
  localparam int N_ICFG         = 4;
endpackage

// File: rtl/alloc_retire_tracker_ptr.sv
// Wrap-bit pointer: PW bits, the MSB toggles on every wrap of the index field.
module tracker_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;

  // next pointer value
  always_comb ptr_d = inc ? ptr_q + 1'b1 : ptr_q;

  // pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/alloc_retire_tracker.sv
// In-order tracker between the read-pipeline allocator and the read-issue
// stage: queues granted allocations, offers them for issue, returns a free
// pulse per retired entry and signals when a closed block has drained.
module alloc_retire_tracker
  import TauCfg::*;
#(
  parameter  int LBW     = LOCAL_ADDR_BW0,
  parameter  int DEPTH   = 8,
  localparam int ICFG_BW = $clog2(N_ICFG + 1),
  localparam int DBW     = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               linear_rdy,
  output logic               linear_ack,
  input  logic [LBW-1:0]     i_linear,
  input  logic [ICFG_BW-1:0] i_linear_id,
  output logic               issue_rdy,
  input  logic               issue_ack,
  output logic [LBW-1:0]     o_issue_linear,
  output logic [ICFG_BW-1:0] o_issue_id,
  input  logic               retire_dval,
  output logic               free_dval,
  output logic [ICFG_BW-1:0] o_free_id,
  input  logic               blkend_dval,
  output logic               blkdone_dval,
  output logic [DBW:0]       o_count,
  output logic               o_err
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [DBW:0] FULL_CNT = (DBW+1)'(DEPTH);

  typedef struct packed {
    logic [LBW-1:0]     linear;
    logic [ICFG_BW-1:0] id;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DBW:0]       wptr, iptr, rptr, count;
  logic [1:0]         state_q, state_d;
  logic               free_q, free_d, err_q, err_d;
  logic [ICFG_BW-1:0] free_id_q, free_id_d;
  logic               full, issue_fire, retire_ok;

  tracker_ptr #(.PW(DBW+1)) u_wptr (.clk(i_clk), .rst_n(i_rst_n), .inc(linear_ack), .ptr(wptr));
  tracker_ptr #(.PW(DBW+1)) u_iptr (.clk(i_clk), .rst_n(i_rst_n), .inc(issue_fire), .ptr(iptr));
  tracker_ptr #(.PW(DBW+1)) u_rptr (.clk(i_clk), .rst_n(i_rst_n), .inc(retire_ok),  .ptr(rptr));

  // occupancy, handshakes and the offered entry
  always_comb begin
    count          = wptr - rptr;
    full           = (count == FULL_CNT);
    // reset gating keeps the ack low while the block is held in reset
    linear_ack     = i_rst_n && linear_rdy && !full && (state_q == ST_IDLE);
    issue_rdy      = (iptr != wptr);
    issue_fire     = issue_rdy && issue_ack;
    retire_ok      = retire_dval && (rptr != iptr);
    o_issue_linear = mem_q[iptr[DBW-1:0]].linear;
    o_issue_id     = mem_q[iptr[DBW-1:0]].id;
  end

  // entry write; the write slot never aliases the slot being retired since
  // an ack requires the queue to be non-full
  always_comb begin
    mem_d = mem_q;
    if (linear_ack) mem_d[wptr[DBW-1:0]] = '{linear: i_linear, id: i_linear_id};
  end

  // free pulse, error flag and block FSM next-state
  always_comb begin
    free_d    = retire_ok;
    free_id_d = retire_ok ? mem_q[rptr[DBW-1:0]].id : free_id_q;
    err_d     = err_q | (retire_dval && !retire_ok) | (blkend_dval && state_q != ST_IDLE);
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if (blkend_dval) state_d = ST_DRAIN;
      // wait for the last free to be out so blkdone trails it
      ST_DRAIN: if (count == '0 && !free_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q   <= ST_IDLE;
      free_q    <= 1'b0;
      free_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      free_q    <= free_d;
      free_id_q <= free_id_d;
      err_q     <= err_d;
    end
  end

  assign free_dval    = free_q;
  assign o_free_id    = free_id_q;
  assign blkdone_dval = (state_q == ST_DONE);
  assign o_count      = count;
  assign o_err        = err_q;
endmodule

// File: tb/tb_alloc_retire_tracker.sv
// Randomized bench for alloc_retire_tracker against a queue-level model.
module tb_alloc_retire_tracker;
  import TauCfg::*;
  localparam int LBW     = LOCAL_ADDR_BW0;
  localparam int DEPTH   = 8;
  localparam int ICFG_BW = $clog2(N_ICFG + 1);
  localparam int DBW     = $clog2(DEPTH);

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               linear_rdy = 1'b0, linear_ack;
  logic [LBW-1:0]     i_linear = '0;
  logic [ICFG_BW-1:0] i_linear_id = '0;
  logic               issue_rdy, issue_ack = 1'b0;
  logic [LBW-1:0]     o_issue_linear;
  logic [ICFG_BW-1:0] o_issue_id;
  logic               retire_dval = 1'b0, free_dval;
  logic [ICFG_BW-1:0] o_free_id;
  logic               blkend_dval = 1'b0, blkdone_dval;
  logic [DBW:0]       o_count;
  logic               o_err;

  alloc_retire_tracker #(.LBW(LBW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .linear_rdy(linear_rdy), .linear_ack(linear_ack),
    .i_linear(i_linear), .i_linear_id(i_linear_id),
    .issue_rdy(issue_rdy), .issue_ack(issue_ack),
    .o_issue_linear(o_issue_linear), .o_issue_id(o_issue_id),
    .retire_dval(retire_dval), .free_dval(free_dval), .o_free_id(o_free_id),
    .blkend_dval(blkend_dval), .blkdone_dval(blkdone_dval),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // reference model: entries held oldest-first, how many of them are issued,
  // pending free pulse, sticky error, block phase (0 open, 1 draining, 2 done)
  typedef struct {
    logic [LBW-1:0]     a;
    logic [ICFG_BW-1:0] id;
  } ent_t;
  ent_t               q[$];
  int                 n_iss;
  bit                 fp_v;
  logic [ICFG_BW-1:0] fp_id;
  bit                 m_err;
  int                 mode;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    n_iss = 0; fp_v = 0; fp_id = '0; m_err = 0; mode = 0;
  endtask

  // one clock cycle: drive at negedge, check, then advance the model
  task automatic cycle(input int p_rdy, input int p_iss, input int p_ret,
                       input int p_blk, input bit legal);
    bit e_ack, e_irdy, iss_f, ret_ok;
    ent_t e;
    @(negedge i_clk);
    linear_rdy  = ($urandom_range(0, 99) < p_rdy);
    i_linear    = LBW'($urandom);
    i_linear_id = ICFG_BW'($urandom_range(0, N_ICFG));
    issue_ack   = ($urandom_range(0, 99) < p_iss);
    retire_dval = ($urandom_range(0, 99) < p_ret) && (!legal || n_iss > 0);
    blkend_dval = ($urandom_range(0, 99) < p_blk) && (!legal || mode == 0);
    #1;
    e_ack  = linear_rdy && (q.size() < DEPTH) && (mode == 0);
    e_irdy = (n_iss < q.size());
    chk("linear_ack", 32'(linear_ack), 32'(e_ack));
    chk("issue_rdy", 32'(issue_rdy), 32'(e_irdy));
    if (e_irdy) begin
      chk("issue_linear", 32'(o_issue_linear), 32'(q[n_iss].a));
      chk("issue_id", 32'(o_issue_id), 32'(q[n_iss].id));
    end
    chk("free_dval", 32'(free_dval), 32'(fp_v));
    if (fp_v) chk("free_id", 32'(o_free_id), 32'(fp_id));
    chk("blkdone", 32'(blkdone_dval), 32'(mode == 2));
    chk("count", 32'(o_count), 32'(q.size()));
    chk("err", 32'(o_err), 32'(m_err));
    // advance model as of the coming edge
    iss_f  = e_irdy && issue_ack;
    ret_ok = retire_dval && (n_iss > 0);
    if (retire_dval && !ret_ok) m_err = 1;
    if (blkend_dval && mode != 0) m_err = 1;
    case (mode)
      0: if (blkend_dval) mode = 1;
      1: if (q.size() == 0 && !fp_v) mode = 2;
      default: mode = 0;
    endcase
    fp_v = ret_ok;
    if (ret_ok) begin
      fp_id = q[0].id;
      void'(q.pop_front());
      n_iss--;
    end
    if (iss_f) n_iss++;
    if (e_ack) begin
      e.a = i_linear; e.id = i_linear_id;
      q.push_back(e);
    end
  endtask

  // async reset between edges; outputs must fall immediately
  task automatic do_reset();
    @(negedge i_clk);
    #2;
    linear_rdy = 1'b1; issue_ack = 1'b0; retire_dval = 1'b0; blkend_dval = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(linear_ack), 0);
    chk("rst_irdy", 32'(issue_rdy), 0);
    chk("rst_free", 32'(free_dval), 0);
    chk("rst_free_id", 32'(o_free_id), 0);
    chk("rst_done", 32'(blkdone_dval), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_err", 32'(o_err), 0);
    model_clear();
    linear_rdy = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();
    // fill toward full with sparse issue/retire
    repeat (40)  cycle(90, 5, 5, 0, 1);
    // mixed traffic with occasional block ends
    repeat (200) cycle(60, 60, 60, 3, 1);
    // saturated accept/issue/retire
    repeat (30)  cycle(100, 100, 100, 0, 1);
    // frequent block ends, including on an empty queue
    repeat (150) cycle(40, 70, 70, 12, 1);
    repeat (20)  cycle(0, 0, 0, 30, 1);
    // load a few entries then reset mid-flight
    repeat (6)   cycle(100, 30, 0, 0, 1);
    do_reset();
    repeat (30)  cycle(50, 50, 50, 2, 1);
    // protocol errors allowed: stray retires and block ends
    repeat (200) cycle(50, 50, 60, 15, 0);
    do_reset();
    repeat (20)  cycle(50, 50, 50, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
